// File: rtl/oled_spi_rx.sv
// rtl/oled_spi_rx.sv - OLED SPI receive monitor: sync, deserialise, tag cmd/data, output FIFO
// Optional OLED_RX_CMD_DECODE_EN adds o_display_on tracking of 0xAF/0xAE commands.
module oled_spi_rx #(
    parameter int IDLE_CYCLES = 1000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_oled_sclk,
    input  logic        i_oled_sdin,
    input  logic        i_oled_dc_n,
    input  logic        i_oled_rst_n,
    output logic [7:0]  o_data,
    output logic        o_dc_n,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_overflow,
    output logic        o_frag_err,
    output logic [15:0] o_byte_count,
    output logic        o_busy
`ifdef OLED_RX_CMD_DECODE_EN
    ,
    output logic        o_display_on
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync_m_q, sync_m_d;
    logic [3:0]    sync_s_q, sync_s_d;
    logic          sclk_d_q, sclk_d_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          tag_q, tag_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          ovf_q, ovf_d;
    logic          frag_q, frag_d;
    logic [15:0]   count_q, count_d;

    logic sclk_s, sdin_s, dc_s, rst_s;
    logic edge_det, timeout;
    logic push, frag_set, start, step;
    logic full, pop, accept;

    assign sclk_s   = sync_s_q[0];
    assign sdin_s   = sync_s_q[1];
    assign dc_s     = sync_s_q[2];
    assign rst_s    = sync_s_q[3];
    // Display reset masks edges so a byte cannot start while the panel is held in reset.
    assign edge_det = sclk_s & ~sclk_d_q & rst_s;
    assign timeout  = (idle_q == IW'(IDLE_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (edge_det) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!rst_s)                             state_d = ST_IDLE;
                else if (edge_det && bit_cnt_q == 3'd7) state_d = ST_DONE;
                else if (!edge_det && timeout)          state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (!rst_s)        state_d = ST_IDLE;
                else if (edge_det) state_d = ST_SHIFT;
                else               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push     = 1'b0;
        frag_set = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        o_busy   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                start = edge_det;
            end
            ST_SHIFT: begin
                o_busy   = 1'b1;
                step     = edge_det;
                frag_set = !rst_s || (!edge_det && timeout);
            end
            ST_DONE: begin
                o_busy   = 1'b1;
                push     = rst_s;
                start    = edge_det;
                frag_set = !rst_s;
            end
            default: ;
        endcase
    end

    assign o_valid = (wr_q != rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = o_valid & i_ready;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign accept  = push & (~full | pop);

    always_comb begin
        sync_m_d  = {i_oled_rst_n, i_oled_dc_n, i_oled_sdin, i_oled_sclk};
        sync_s_d  = sync_m_q;
        sclk_d_d  = sclk_s;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tag_d     = tag_q;
        idle_d    = '0;
        if (start) begin
            shift_d   = {7'd0, sdin_s};
            bit_cnt_d = 3'd1;
        end else if (step) begin
            shift_d   = {shift_q[6:0], sdin_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) tag_d = dc_s;
        end else if (state_q == ST_SHIFT && !timeout) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q + (AW+1)'(accept);
        rd_d    = rd_q + (AW+1)'(pop);
        count_d = count_q + 16'(accept);
        ovf_d   = ovf_q | (push & full & ~pop);
        frag_d  = frag_q | frag_set;
        if (accept) mem_d[wr_q[AW-1:0]] = {tag_q, shift_q};
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            sync_m_q  <= '0;
            sync_s_q  <= '0;
            sclk_d_q  <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tag_q     <= 1'b0;
            idle_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            ovf_q     <= 1'b0;
            frag_q    <= 1'b0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync_m_q  <= sync_m_d;
            sync_s_q  <= sync_s_d;
            sclk_d_q  <= sclk_d_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tag_q     <= tag_d;
            idle_q    <= idle_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            ovf_q     <= ovf_d;
            frag_q    <= frag_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
        end
    end

    assign o_data       = mem_q[rd_q[AW-1:0]][7:0];
    assign o_dc_n       = mem_q[rd_q[AW-1:0]][8];
    assign o_overflow   = ovf_q;
    assign o_frag_err   = frag_q;
    assign o_byte_count = count_q;

`ifdef OLED_RX_CMD_DECODE_EN
    logic disp_q, disp_d;

    // Decoded on the attempted push, so a full FIFO does not hide the command.
    always_comb begin
        disp_d = disp_q;
        if (!rst_s) begin
            disp_d = 1'b0;
        end else if (push && !tag_q) begin
            if (shift_q == 8'hAF) disp_d = 1'b1;
            if (shift_q == 8'hAE) disp_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            disp_q <= 1'b0;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign o_display_on = disp_q;
`endif

endmodule
